// File: rtl/dec_scrub_pkg.sv
// Shared types and default sizes for the DEC memory scrubber.
package dec_scrub_pkg;

  localparam int DEF_CW_W  = 45;  // 32 data + 13 DEC/TED check bits
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    CHECK   = 3'd3,
    WR_REQ  = 3'd4,
    NEXT    = 3'd5
  } scrub_state_e;

endpackage

// File: rtl/dec_scrub_ctrl_sat_counter.sv
// Saturating event counter: synchronous clear wins over increment, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear, or increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dec_scrub_ctrl.sv
// DEC memory scrubber: walks every word, reads it through an external
// combinational DEC decoder, writes back corrected words and counts errors.
// Optional SCRUB_ERR_LOG_EN adds ue_addr, the address of the last
// uncorrectable word.
module dec_scrub_ctrl
  import dec_scrub_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CW_W   = DEF_CW_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic [CW_W-1:0]   dec_cw,
  input  logic [CW_W-1:0]   dec_corr,
  input  logic [1:0]        dec_nerr,
  input  logic              dec_ued,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
`ifdef SCRUB_ERR_LOG_EN
  output logic [ADDR_W-1:0] ue_addr,
`endif
  output logic              irq_ue
);

  scrub_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [CW_W-1:0]   wdata_q, wdata_d;
  logic              irq_q, irq_d;

  logic kick, last_word, ue_hit, ce_hit;

  // start only counts from IDLE; a pulse mid-pass is dropped
  assign kick      = (state_q == IDLE) && start;
  assign last_word = (addr_q == {ADDR_W{1'b1}});
  // uncorrectable takes priority over any reported correction
  assign ue_hit    = (state_q == CHECK) && dec_ued;
  assign ce_hit    = (state_q == CHECK) && !dec_ued && (dec_nerr != 2'd0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; stop is only looked at in NEXT so accesses always finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = RD_REQ;
      RD_REQ:  if (mem_gnt)    state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_d = CHECK;
      CHECK:   state_d = ce_hit ? WR_REQ : NEXT;
      WR_REQ:  if (mem_gnt)    state_d = NEXT;
      NEXT:    state_d = (last_word || stop) ? IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state; request fields come straight from registers
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      RD_REQ:  mem_req = 1'b1;
      WR_REQ:  begin mem_req = 1'b1; mem_we = 1'b1; end
      NEXT:    done = last_word;
      default: ;
    endcase
  end

  // datapath next values: address walk, captured codeword, writeback data, sticky irq
  always_comb begin
    addr_d  = addr_q;
    cw_d    = cw_q;
    wdata_d = wdata_q;
    irq_d   = irq_q;
    if (kick) begin
      addr_d = '0;
      irq_d  = 1'b0;
    end
    if (state_q == RD_WAIT && mem_rvalid)            cw_d    = mem_rdata;
    if (ce_hit)                                       wdata_d = dec_corr;
    if (ue_hit)                                       irq_d   = 1'b1;
    if (state_q == NEXT && !last_word && !stop)       addr_d  = addr_q + ADDR_W'(1);
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      cw_q    <= '0;
      wdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cw_q    <= cw_d;
      wdata_q <= wdata_d;
      irq_q   <= irq_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dec_cw    = cw_q;
  assign irq_ue    = irq_q;

`ifdef SCRUB_ERR_LOG_EN
  logic [ADDR_W-1:0] ue_addr_q, ue_addr_d;

  // remember where the most recent uncorrectable word lives
  always_comb begin
    ue_addr_d = ue_addr_q;
    if (kick)   ue_addr_d = '0;
    if (ue_hit) ue_addr_d = addr_q;
  end

  // error-log register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ue_addr_q <= '0;
    else        ue_addr_q <= ue_addr_d;
  end

  assign ue_addr = ue_addr_q;
`endif

  sat_counter #(.W(CNT_W)) u_ce_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (kick),
    .inc_i (ce_hit),
    .cnt_o (ce_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ue_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (kick),
    .inc_i (ue_hit),
    .cnt_o (ue_cnt)
  );

endmodule

// File: tb/tb_dec_scrub_ctrl.sv
// Directed bench for dec_scrub_ctrl. DUT A (4 words) exercises the protocol,
// DUT B (8 words, 2-bit counters) exercises counter saturation.
module tb_dec_scrub_ctrl;

  localparam int AW = 2;
  localparam int BW = 3;
  localparam int CW = 45;
  localparam int CN = 16;
  localparam int BN = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // ---------------- DUT A ----------------
  logic          start_a, stop_a, mem_req_a, mem_we_a, mem_gnt_a, mem_rvalid_a;
  logic [AW-1:0] mem_addr_a;
  logic [CW-1:0] mem_wdata_a, mem_rdata_a, dec_cw_a, dec_corr_a;
  logic [1:0]    dec_nerr_a;
  logic          dec_ued_a, busy_a, done_a, irq_a;
  logic [CN-1:0] ce_a, ue_a;
`ifdef SCRUB_ERR_LOG_EN
  logic [AW-1:0] ue_addr_a;
`endif

  dec_scrub_ctrl #(.ADDR_W(AW), .CW_W(CW), .CNT_W(CN)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_gnt(mem_gnt_a), .mem_rvalid(mem_rvalid_a),
    .mem_rdata(mem_rdata_a), .dec_cw(dec_cw_a), .dec_corr(dec_corr_a),
    .dec_nerr(dec_nerr_a), .dec_ued(dec_ued_a), .busy(busy_a), .done(done_a),
    .ce_cnt(ce_a), .ue_cnt(ue_a),
`ifdef SCRUB_ERR_LOG_EN
    .ue_addr(ue_addr_a),
`endif
    .irq_ue(irq_a)
  );

  // memory contents carry their own address in the low bits; decoder verdict tables per word
  logic [CW-1:0] mem_a  [4];
  logic [1:0]    nerr_t [4];
  logic          ued_t  [4];
  logic [CW-1:0] corr_t [4];
  logic [1:0]    idx_a;
  assign idx_a      = dec_cw_a[1:0];
  assign dec_nerr_a = nerr_t[idx_a];
  assign dec_ued_a  = ued_t[idx_a];
  assign dec_corr_a = corr_t[idx_a];

  int            nrd_a, nwr_a, ndone_a, stab_err, wr_wait, wcnt, gnt_dly;
  bit            no_rv;
  logic [AW-1:0] wr_addr_log, hold_addr, cap_addr;
  logic [CW-1:0] wr_data_log, hold_wdata, cap_wdata;
  logic          hold_we, cap_we;

  // memory responder A: delayed grant, read data one cycle after acceptance
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_gnt_a = 1'b0; mem_rvalid_a = 1'b0; wcnt = 0;
    end else begin
      mem_rvalid_a = 1'b0;
      if (done_a) ndone_a++;
      if (mem_gnt_a) begin
        mem_gnt_a = 1'b0;
        if (cap_we) begin
          nwr_a++; wr_addr_log = cap_addr; wr_data_log = cap_wdata; wr_wait = wcnt;
        end else begin
          nrd_a++;
          if (!no_rv) begin mem_rvalid_a = 1'b1; mem_rdata_a = mem_a[cap_addr]; end
        end
        wcnt = 0;
      end else if (mem_req_a) begin
        if (wcnt == 0) begin
          hold_we = mem_we_a; hold_addr = mem_addr_a; hold_wdata = mem_wdata_a;
        end else if (mem_we_a !== hold_we || mem_addr_a !== hold_addr ||
                     (mem_we_a && mem_wdata_a !== hold_wdata)) begin
          stab_err++;
        end
        if (wcnt >= gnt_dly) begin
          mem_gnt_a = 1'b1; cap_we = mem_we_a; cap_addr = mem_addr_a; cap_wdata = mem_wdata_a;
        end else wcnt++;
      end else if (wcnt != 0) begin
        stab_err++;  // request withdrawn before grant
        wcnt = 0;
      end
    end
  end

  // ---------------- DUT B ----------------
  logic          start_b, stop_b, mem_req_b, mem_we_b, mem_gnt_b, mem_rvalid_b;
  logic [BW-1:0] mem_addr_b, rd_addr_b;
  logic [CW-1:0] mem_wdata_b, mem_rdata_b, dec_cw_b, dec_corr_b;
  logic [1:0]    dec_nerr_b;
  logic          dec_ued_b, busy_b, done_b, irq_b, rd_pend_b;
  logic [BN-1:0] ce_b, ue_b;
`ifdef SCRUB_ERR_LOG_EN
  logic [BW-1:0] ue_addr_b;
`endif
  int nwr_b, ndone_b;

  dec_scrub_ctrl #(.ADDR_W(BW), .CW_W(CW), .CNT_W(BN)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_gnt(mem_gnt_b), .mem_rvalid(mem_rvalid_b),
    .mem_rdata(mem_rdata_b), .dec_cw(dec_cw_b), .dec_corr(dec_corr_b),
    .dec_nerr(dec_nerr_b), .dec_ued(dec_ued_b), .busy(busy_b), .done(done_b),
    .ce_cnt(ce_b), .ue_cnt(ue_b),
`ifdef SCRUB_ERR_LOG_EN
    .ue_addr(ue_addr_b),
`endif
    .irq_ue(irq_b)
  );

  // words 0..4 are correctable, 5..7 clean
  assign mem_gnt_b  = mem_req_b;
  assign dec_nerr_b = (dec_cw_b < 45'd5) ? 2'd1 : 2'd0;
  assign dec_ued_b  = 1'b0;
  assign dec_corr_b = dec_cw_b ^ 45'h100;

  // memory responder B: immediate grant, data one cycle later
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend_b = 1'b0; mem_rvalid_b = 1'b0;
    end else begin
      if (rd_pend_b) begin
        mem_rvalid_b = 1'b1; mem_rdata_b = CW'(rd_addr_b); rd_pend_b = 1'b0;
      end else mem_rvalid_b = 1'b0;
      if (mem_req_b) begin
        if (mem_we_b) nwr_b++;
        else begin rd_pend_b = 1'b1; rd_addr_b = mem_addr_b; end
      end
      if (done_b) ndone_b++;
    end
  end

  // ---------------- helpers ----------------
  task automatic clr_model();
    for (int i = 0; i < 4; i++) begin
      nerr_t[i] = 2'd0; ued_t[i] = 1'b0; corr_t[i] = '0;
    end
    nrd_a = 0; nwr_a = 0; ndone_a = 0; stab_err = 0; wr_wait = -1;
    wr_addr_log = '0; wr_data_log = '0; gnt_dly = 0; no_rv = 1'b0;
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string nm);
    int n = 0;
    while (busy_a && n < 400) begin @(posedge clk); #1; n++; end
    if (busy_a) begin
      ntests++; nfail++;
      $display("FAIL %s: still busy after %0d cycles, required idle", nm, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 0; stop_a = 0; start_b = 0; stop_b = 0;
    mem_gnt_a = 0; mem_rvalid_a = 0; mem_rdata_a = '0; mem_rdata_b = '0;
    rd_pend_b = 0; mem_rvalid_b = 0; nwr_b = 0; ndone_b = 0;
    clr_model();
    repeat (2) @(posedge clk); #1;
    ntests++; if ({busy_a, done_a, mem_req_a, mem_we_a, irq_a} !== 5'b0) begin nfail++;
      $display("FAIL reset_ctl_a: got %b required 00000", {busy_a, done_a, mem_req_a, mem_we_a, irq_a}); end
    ntests++; if (mem_addr_a !== '0 || mem_wdata_a !== '0 || dec_cw_a !== '0) begin nfail++;
      $display("FAIL reset_data_a: addr %h wdata %h cw %h required 0", mem_addr_a, mem_wdata_a, dec_cw_a); end
    ntests++; if (ce_a !== '0 || ue_a !== '0) begin nfail++;
      $display("FAIL reset_cnt_a: ce %0d ue %0d required 0", ce_a, ue_a); end
    ntests++; if ({busy_b, mem_req_b, ce_b, ue_b, irq_b} !== '0) begin nfail++;
      $display("FAIL reset_b: got %b required 0", {busy_b, mem_req_b, ce_b, ue_b, irq_b}); end
`ifdef SCRUB_ERR_LOG_EN
    ntests++; if (ue_addr_a !== '0) begin nfail++;
      $display("FAIL reset_ue_addr: got %0d required 0", ue_addr_a); end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_pass();
    clr_model();
    pulse_start_a();
    ntests++; if (busy_a !== 1'b1) begin nfail++;
      $display("FAIL clean_busy: got %b required 1", busy_a); end
    wait_idle_a("clean_idle");
    ntests++; if (nrd_a != 4 || nwr_a != 0) begin nfail++;
      $display("FAIL clean_accesses: reads %0d writes %0d required 4/0", nrd_a, nwr_a); end
    ntests++; if (ndone_a != 1) begin nfail++;
      $display("FAIL clean_done: pulses %0d required 1", ndone_a); end
    ntests++; if (ce_a !== 16'd0 || ue_a !== 16'd0 || irq_a !== 1'b0) begin nfail++;
      $display("FAIL clean_cnt: ce %0d ue %0d irq %b required 0/0/0", ce_a, ue_a, irq_a); end
  endtask

  task automatic test_correct_ue();
    clr_model();
    nerr_t[1] = 2'd2; corr_t[1] = 45'h0123456789A;
    ued_t[2]  = 1'b1; nerr_t[2] = 2'd1; corr_t[2] = 45'h777;
    pulse_start_a();
    wait_idle_a("cue_idle");
    ntests++; if (nrd_a != 4 || nwr_a != 1) begin nfail++;
      $display("FAIL cue_accesses: reads %0d writes %0d required 4/1", nrd_a, nwr_a); end
    ntests++; if (wr_addr_log !== 2'd1 || wr_data_log !== 45'h0123456789A) begin nfail++;
      $display("FAIL cue_write: addr %0d data %h required 1/0123456789a", wr_addr_log, wr_data_log); end
    ntests++; if (ce_a !== 16'd1) begin nfail++;
      $display("FAIL cue_ce: got %0d required 1", ce_a); end
    ntests++; if (ue_a !== 16'd1 || irq_a !== 1'b1) begin nfail++;
      $display("FAIL cue_ue: ue %0d irq %b required 1/1", ue_a, irq_a); end
    ntests++; if (ndone_a != 1) begin nfail++;
      $display("FAIL cue_done: pulses %0d required 1", ndone_a); end
`ifdef SCRUB_ERR_LOG_EN
    ntests++; if (ue_addr_a !== 2'd2) begin nfail++;
      $display("FAIL cue_ue_addr: got %0d required 2", ue_addr_a); end
`endif
  endtask

  task automatic test_gnt_delay();
    clr_model();
    nerr_t[3] = 2'd1; corr_t[3] = 45'h1ABCDE00F3;
    gnt_dly = 5;
    pulse_start_a();
    wait_idle_a("gnt_idle");
    ntests++; if (stab_err != 0) begin nfail++;
      $display("FAIL gnt_stable: %0d unstable cycles required 0", stab_err); end
    ntests++; if (nwr_a != 1 || wr_wait != 5) begin nfail++;
      $display("FAIL gnt_write: writes %0d waited %0d required 1/5", nwr_a, wr_wait); end
    ntests++; if (wr_addr_log !== 2'd3 || wr_data_log !== 45'h1ABCDE00F3) begin nfail++;
      $display("FAIL gnt_wdata: addr %0d data %h required 3/1abcde00f3", wr_addr_log, wr_data_log); end
    ntests++; if (ce_a !== 16'd1 || ue_a !== 16'd0 || irq_a !== 1'b0) begin nfail++;
      $display("FAIL gnt_cnt: ce %0d ue %0d irq %b required 1/0/0", ce_a, ue_a, irq_a); end
  endtask

  task automatic test_stop();
    int n = 0;
    clr_model();
    nerr_t[1] = 2'd1; corr_t[1] = 45'h55;
    nerr_t[2] = 2'd1; corr_t[2] = 45'h66;
    gnt_dly = 3;
    pulse_start_a();
    while (!(mem_req_a && mem_we_a) && n < 100) begin @(posedge clk); #1; n++; end
    ntests++; if (!(mem_req_a && mem_we_a && mem_addr_a == 2'd1)) begin nfail++;
      $display("FAIL stop_reach_wr: req %b we %b addr %0d required 1/1/1", mem_req_a, mem_we_a, mem_addr_a); end
    stop_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_idle_a("stop_idle");
    repeat (2) @(posedge clk); #1;
    stop_a = 1'b0;
    ntests++; if (nwr_a != 1 || wr_addr_log !== 2'd1 || wr_data_log !== 45'h55) begin nfail++;
      $display("FAIL stop_write: writes %0d addr %0d data %h required 1/1/55", nwr_a, wr_addr_log, wr_data_log); end
    ntests++; if (nrd_a != 2 || ndone_a != 0 || busy_a !== 1'b0) begin nfail++;
      $display("FAIL stop_end: reads %0d done %0d busy %b required 2/0/0", nrd_a, ndone_a, busy_a); end
    ntests++; if (ce_a !== 16'd1) begin nfail++;
      $display("FAIL stop_ce: got %0d required 1", ce_a); end
`ifdef SCRUB_ERR_LOG_EN
    ntests++; if (ue_addr_a !== 2'd0) begin nfail++;
      $display("FAIL stop_ue_addr: got %0d required 0", ue_addr_a); end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clr_model();
    nerr_t[0] = 2'd1; corr_t[0] = 45'h1F;
    ued_t[1]  = 1'b1;
    pulse_start_a();
    while (nrd_a < 2 && n < 100) begin @(posedge clk); #1; n++; end
    no_rv = 1'b1;
    while (nrd_a < 3 && n < 200) begin @(posedge clk); #1; n++; end
    ntests++; if (nrd_a != 3 || ce_a !== 16'd1 || ue_a !== 16'd1 || mem_addr_a !== 2'd2) begin nfail++;
      $display("FAIL rmid_pre: reads %0d ce %0d ue %0d addr %0d required 3/1/1/2", nrd_a, ce_a, ue_a, mem_addr_a); end
    #2 rst_n = 1'b0;
    #1;
    ntests++; if ({busy_a, mem_req_a, mem_we_a, done_a, irq_a} !== 5'b0 || mem_addr_a !== '0) begin nfail++;
      $display("FAIL rmid_ctl: got %b addr %0d required 0", {busy_a, mem_req_a, mem_we_a, done_a, irq_a}, mem_addr_a); end
    ntests++; if (dec_cw_a !== '0 || mem_wdata_a !== '0) begin nfail++;
      $display("FAIL rmid_data: cw %h wdata %h required 0", dec_cw_a, mem_wdata_a); end
    ntests++; if (ce_a !== '0 || ue_a !== '0) begin nfail++;
      $display("FAIL rmid_cnt: ce %0d ue %0d required 0", ce_a, ue_a); end
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    ntests++; if (ndone_a != 0 || busy_a !== 1'b0) begin nfail++;
      $display("FAIL rmid_after: done %0d busy %b required 0/0", ndone_a, busy_a); end
  endtask

  task automatic test_saturate();
    int n = 0;
    nwr_b = 0; ndone_b = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    while (busy_b && n < 400) begin @(posedge clk); #1; n++; end
    ntests++; if (busy_b !== 1'b0) begin nfail++;
      $display("FAIL sat_idle: still busy after %0d cycles", n); end
    ntests++; if (ce_b !== 2'd3 || ue_b !== 2'd0) begin nfail++;
      $display("FAIL sat_ce: ce %0d ue %0d required 3/0", ce_b, ue_b); end
    ntests++; if (nwr_b != 5 || ndone_b != 1) begin nfail++;
      $display("FAIL sat_pass: writes %0d done %0d required 5/1", nwr_b, ndone_b); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem_a[i] = 45'h1000 + 45'(i);
    test_reset();
    test_clean_pass();
    test_correct_ue();
    test_gnt_delay();
    test_stop();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dec_scrub_ctrl.md
DEC_SCRUB_CTRL -- requirements
Module: dec_scrub_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: memory word-address width; one scrub pass covers 2^ADDR_W words.
REQ-002 Parameter CW_W, default 45: stored codeword width (32 data + 13 DEC/TED check bits).
REQ-003 Parameter CNT_W, default 16: error-counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a pass at address 0 when idle.
REQ-007 stop  input  1  level; abort the pass after the current word completes.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-010 mem_addr  output  ADDR_W  access address; valid while mem_req.
REQ-011 mem_wdata  output  CW_W  write codeword; valid while mem_req and mem_we.
REQ-012 mem_gnt  input  1  request accepted this cycle.
REQ-013 mem_rvalid  input  1  read data valid, one-cycle pulse.
REQ-014 mem_rdata  input  CW_W  read codeword.
REQ-015 dec_cw  output  CW_W  registered codeword driven to the external combinational DEC decoder.
REQ-016 dec_corr  input  CW_W  corrected codeword from the decoder.
REQ-017 dec_nerr  input  2  errors corrected (0, 1 or 2).
REQ-018 dec_ued  input  1  uncorrectable (triple) error detected.
REQ-019 busy  output  1  pass in progress.
REQ-020 done  output  1  one-cycle pulse at completion of a full pass.
REQ-021 ce_cnt  output  CNT_W  corrected-word count.
REQ-022 ue_cnt  output  CNT_W  uncorrectable-word count.
REQ-023 irq_ue  output  1  sticky uncorrectable-error flag.

Function
REQ-024 The FSM SHALL use states IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
REQ-025 IDLE->RD_REQ on start; start while busy SHALL be ignored; start SHALL clear ce_cnt, ue_cnt, irq_ue and set the address to 0.
REQ-026 RD_REQ: mem_req=1, mem_we=0; mem_req, mem_addr and mem_we SHALL stay stable until mem_gnt, then go to RD_WAIT.
REQ-027 RD_WAIT: on mem_rvalid, register mem_rdata into dec_cw and go to CHECK; mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-028 CHECK (exactly one cycle): dec_ued=1 -> ue_cnt+1, irq_ue=1, no writeback, go to NEXT; dec_ued=0 and dec_nerr!=0 -> ce_cnt+1, latch dec_corr into mem_wdata, go to WR_REQ; otherwise go to NEXT.
REQ-029 dec_ued SHALL take priority over dec_nerr.
REQ-030 WR_REQ: mem_req=1, mem_we=1, same address; held until mem_gnt, then go to NEXT.
REQ-031 NEXT: when the address equals 2^ADDR_W-1, pulse done and go to IDLE; when stop=1, go to IDLE without done; otherwise increment the address and go to RD_REQ.
REQ-032 Counters SHALL saturate at all-ones and never wrap.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 stop SHALL never truncate an in-flight read or writeback.

Reset
REQ-035 While rst_n=0, the block SHALL hold state IDLE and set every output (including dec_cw, mem_wdata and the counters) to 0.
REQ-036 Reset asserted mid-pass SHALL abandon the pass immediately, with no done pulse; the memory interface is also reset.

Configuration
REQ-037 With SCRUB_ERR_LOG_EN defined, the block SHALL add output ue_addr (ADDR_W), holding the address of the most recent uncorrectable word (0 after reset or start).
REQ-038 Without SCRUB_ERR_LOG_EN, the ue_addr port and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-039 Package dec_scrub_pkg SHALL hold the state enum type and the default constants CW_W=45 and CNT_W=16.
REQ-040 Sub-module sat_counter (synchronous clear, increment, saturate) SHALL implement ce_cnt and ue_cnt.

Verification
REQ-041 ADDR_W=2, clean memory, start -> 4 reads, no writes, done pulses once, ce_cnt=0, ue_cnt=0.
REQ-042 Word 1 decoded with dec_nerr=2 and dec_corr=45'h0123456789A -> write to address 1 with that data, ce_cnt=1.
REQ-043 Word 2 decoded with dec_ued=1 and dec_nerr=1 -> no write, ue_cnt=1, irq_ue=1, ue_addr=2 (with macro), ce_cnt unchanged.
REQ-044 mem_gnt delayed 5 cycles on a writeback -> mem_req, mem_addr and mem_wdata stable for all 5 cycles; exactly one write.
REQ-045 stop asserted during WR_REQ at address 1 -> writeback completes, IDLE follows, busy=0, done never pulses; start mid-pass is ignored.
REQ-046 CNT_W=2 with 5 correctable words -> ce_cnt sticks at 3; rst_n dropped mid-RD_WAIT -> all outputs 0 asynchronously.
